// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared state encoding and mux select constants for the FP divide sequencer
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT_Q = 3'd1,
        INIT_D = 3'd2,
        ITER_Q = 3'd3,
        ITER_D = 3'd4,
        REM    = 3'd5,
        DONE   = 3'd6
    } fpdiv_state_t;

    localparam logic [1:0] SELA_K  = 2'b00;
    localparam logic [1:0] SELA_D  = 2'b01;
    localparam logic [1:0] SELA_IA = 2'b10;

    localparam logic [1:0] SELB_D  = 2'b00;
    localparam logic [1:0] SELB_X  = 2'b01;
    localparam logic [1:0] SELB_Q  = 2'b10;
    localparam logic [1:0] SELB_DR = 2'b11;

endpackage

// File: rtl/fpdiv_seq_ctrl.sv
// rtl/fpdiv_seq_ctrl.sv - Moore sequencer driving the Goldschmidt divide datapath selects and enables
module fpdiv_seq_ctrl
    import fpdiv_pkg::*;
#(
    parameter int ITERS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rmode_in,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       rmode,
    output logic [1:0] sel_muxa,
    output logic [1:0] sel_muxb,
    output logic       enA,
    output logic       enB,
    output logic       enC,
    output logic       enR
);

    localparam int IW = $clog2(ITERS + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(ITERS - 1);

    generate
        if (ITERS < 1 || ITERS > 7) begin : g_bad_iters
            $error("fpdiv_seq_ctrl: ITERS must be in 1..7");
        end
    endgenerate

    fpdiv_state_t    state;
    logic [IW-1:0]   iter;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
            rmode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= INIT_Q;
                        iter  <= '0;
                        rmode <= rmode_in;
                    end
                end
                INIT_Q: state <= INIT_D;
                INIT_D: state <= ITER_Q;
                ITER_Q: state <= ITER_D;
                ITER_D: begin
                    if (iter == ITER_LAST) begin
                        state <= REM;
                        iter  <= '0;
                    end else begin
                        state <= ITER_Q;
                        iter  <= iter + IW'(1);
                    end
                end
                REM: state <= DONE;
                // A start seen while presenting the result begins the next op with no idle bubble
                DONE: begin
                    if (start) begin
                        state <= INIT_Q;
                        iter  <= '0;
                        rmode <= rmode_in;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    iter  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        sel_muxa = SELA_K;
        sel_muxb = SELB_D;
        enA      = 1'b0;
        enB      = 1'b0;
        enC      = 1'b0;
        enR      = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            INIT_Q: begin
                busy     = 1'b1;
                sel_muxa = SELA_IA;
                sel_muxb = SELB_X;
                enB      = 1'b1;
            end
            INIT_D: begin
                busy     = 1'b1;
                sel_muxa = SELA_IA;
                sel_muxb = SELB_D;
                enA      = 1'b1;
                enC      = 1'b1;
            end
            // Q is refined with the K from the previous step, before K is replaced in ITER_D
            ITER_Q: begin
                busy     = 1'b1;
                sel_muxa = SELA_K;
                sel_muxb = SELB_Q;
                enB      = 1'b1;
            end
            ITER_D: begin
                busy     = 1'b1;
                sel_muxa = SELA_K;
                sel_muxb = SELB_DR;
                enA      = 1'b1;
                enC      = 1'b1;
            end
            REM: begin
                busy     = 1'b1;
                sel_muxa = SELA_D;
                sel_muxb = SELB_Q;
                enR      = 1'b1;
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// tb/tb_fpdiv_seq_ctrl.sv - directed bench for the FP divide sequencer, with a datapath model on an ITERS=1 instance
module tb_fpdiv_seq_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic rmode_in = 1'b0;
    logic ready, busy, done, rmode;
    logic [1:0] sel_muxa, sel_muxb;
    logic enA, enB, enC, enR;

    logic start1 = 1'b0;
    logic ready1, busy1, done1, rmode1;
    logic [1:0] sel_muxa1, sel_muxb1;
    logic enA1, enB1, enC1, enR1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fpdiv_seq_ctrl #(.ITERS(3)) dut (
        .clock(clock), .reset(reset), .start(start), .rmode_in(rmode_in),
        .ready(ready), .busy(busy), .done(done), .rmode(rmode),
        .sel_muxa(sel_muxa), .sel_muxb(sel_muxb),
        .enA(enA), .enB(enB), .enC(enC), .enR(enR)
    );

    fpdiv_seq_ctrl #(.ITERS(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .rmode_in(1'b0),
        .ready(ready1), .busy(busy1), .done(done1), .rmode(rmode1),
        .sel_muxa(sel_muxa1), .sel_muxb(sel_muxb1),
        .enA(enA1), .enB(enB1), .enC(enC1), .enR(enR1)
    );

    // Datapath model for the ITERS=1 instance: 1.27 fixed point, product[54:27] written back
    localparam logic [27:0] D_OP  = 28'hC000000;
    localparam logic [27:0] X_OP  = 28'h8000000;
    localparam logic [27:0] IA_OP = 28'h5555555;
    logic [27:0] reg_a, reg_b, reg_c, reg_r, mux_a, mux_b;
    logic [55:0] product;

    always_comb begin
        mux_a = reg_a;
        case (sel_muxa1)
            2'b01:   mux_a = D_OP;
            2'b10:   mux_a = IA_OP;
            default: mux_a = reg_a;
        endcase
        case (sel_muxb1)
            2'b00:   mux_b = D_OP;
            2'b01:   mux_b = X_OP;
            2'b10:   mux_b = reg_b;
            default: mux_b = reg_c;
        endcase
        product = {28'b0, mux_a} * {28'b0, mux_b};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_a <= '0; reg_b <= '0; reg_c <= '0; reg_r <= '0;
        end else begin
            if (enA1) reg_a <= ~product[54:27];
            if (enB1) reg_b <= product[54:27];
            if (enC1) reg_c <= product[54:27];
            if (enR1) reg_r <= product[54:27];
        end
    end

    function automatic logic [27:0] fx_mul(input logic [27:0] a, input logic [27:0] b);
        logic [55:0] p;
        p = {28'b0, a} * {28'b0, b};
        return p[54:27];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // {sel_muxa, sel_muxb, enA, enB, enC, enR, done} expected in cycle c after a start in cycle 0 (ITERS=3)
    function automatic logic [8:0] exp_vec(input int c);
        case (c)
            1:         return 9'b10_01_0100_0;
            2:         return 9'b10_00_1010_0;
            3, 5, 7:   return 9'b00_10_0100_0;
            4, 6, 8:   return 9'b00_11_1010_0;
            9:         return 9'b01_10_0001_0;
            10:        return 9'b00_00_0000_1;
            default:   return 9'b00_00_0000_0;
        endcase
    endfunction

    function automatic logic [8:0] obs_vec();
        return {sel_muxa, sel_muxb, enA, enB, enC, enR, done};
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(ready && !done) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!(ready && !done)) begin
            errors++;
            $display("FAIL %s: sequencer not idle after %0d cycles (ready=%b done=%b)", name, n, ready, done);
        end
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        reset = 1'b1;
        step();
        step();
        obs = {ready, busy, done, sel_muxa, sel_muxb, enA, enB, enC, enR};
        checks++;
        if (obs !== 11'b100_00_00_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 11'b100_00_00_0000);
        end
        checks++;
        if (rmode !== 1'b0) begin
            errors++;
            $display("FAIL reset_rmode: got %b expected 0", rmode);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (obs_vec() !== exp_vec(c) || busy !== (c != 10) || ready !== (c == 10)) begin
                errors++;
                $display("FAIL single_cycle%0d: got %b busy=%b ready=%b expected %b busy=%b ready=%b",
                         c, obs_vec(), busy, ready, exp_vec(c), (c != 10), (c == 10));
            end
            if (c != 10) step();
        end
        step();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || obs_vec() !== 9'b0) begin
            errors++;
            $display("FAIL single_return_idle: got ready=%b busy=%b vec=%b expected 1 0 0", ready, busy, obs_vec());
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        start = 1'b1;
        step();
        for (int c = 1; c <= 31; c++) begin
            if (done) ndone++;
            checks++;
            if (obs_vec() !== exp_vec(((c - 1) % 10) + 1)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %b expected %b", c, obs_vec(), exp_vec(((c - 1) % 10) + 1));
            end
            if (c != 31) step();
        end
        start = 1'b0;
        checks++;
        if (ndone != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 3", ndone);
        end
        wait_idle("b2b_drain");
    endtask

    task automatic test_reset_mid();
        logic bad;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        checks++;
        if (obs_vec() !== exp_vec(6)) begin
            errors++;
            $display("FAIL midreset_pre: got %b expected %b", obs_vec(), exp_vec(6));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || {enA, enB, enC, enR} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_idle: got ready=%b busy=%b en=%b expected 1 0 0000",
                     ready, busy, {enA, enB, enC, enR});
        end
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done || enA || enB || enC || enR) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got activity=%b expected 0", bad);
        end
    endtask

    task automatic test_rmode();
        logic bad;
        rmode_in = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        rmode_in = 1'b0;
        bad = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (rmode !== 1'b1) bad = 1'b1;
            if (c != 10) step();
        end
        checks++;
        if (bad !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL rmode_hold: got dropped=%b done=%b expected 0 1", bad, done);
        end
        step();
        checks++;
        if (rmode !== 1'b1) begin
            errors++;
            $display("FAIL rmode_idle_hold: got %b expected 1", rmode);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (rmode !== 1'b0) begin
            errors++;
            $display("FAIL rmode_reload: got %b expected 0", rmode);
        end
        wait_idle("rmode_drain");
    endtask

    task automatic test_iters1_datapath();
        int lat;
        logic [27:0] gq, gd, gk, gr;
        int diff;
        gq = fx_mul(IA_OP, X_OP);
        gd = fx_mul(IA_OP, D_OP);
        gk = ~gd;
        gq = fx_mul(gk, gq);
        gd = fx_mul(gk, gd);
        gr = fx_mul(D_OP, gq);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (!done1 || lat != 6) begin
            errors++;
            $display("FAIL iters1_latency: got done=%b at cycle %0d expected done at cycle 6", done1, lat);
        end
        diff = int'(reg_b) - int'(28'h5555555);
        checks++;
        if (diff > 2 || diff < -2) begin
            errors++;
            $display("FAIL iters1_quotient_ulp: got %h expected 5555555 within 2 ulp", reg_b);
        end
        checks++;
        if (reg_b !== gq || reg_r !== gr) begin
            errors++;
            $display("FAIL iters1_golden: got q=%h r=%h expected q=%h r=%h", reg_b, reg_r, gq, gr);
        end
        step();
        checks++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL iters1_idle: got ready=%b busy=%b done=%b expected 1 0 0", ready1, busy1, done1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_rmode();
        test_iters1_datapath();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
